// File: rtl/hawk_page_rd_seq.sv
// Page read sequencer: splits one page-read command into INCR AR bursts with a bounded
// number in flight, and forwards the R beats to the compressor as a flow-controlled stream.
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 512
`endif
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 64
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif

module hawk_page_rd_seq #(
  parameter int unsigned DATA_WIDTH      = `HACD_AXI4_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH      = `HACD_AXI4_ADDR_WIDTH,
  parameter int unsigned ID_WIDTH        = `HACD_AXI4_ID_WIDTH,
  parameter int unsigned RD_ID           = 0,
  parameter int unsigned PAGE_BYTES      = 4096,
  parameter int unsigned BURST_BEATS     = 8,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned BYTES          = DATA_WIDTH / 8;
  localparam int unsigned BEATS_PER_PAGE = PAGE_BYTES / BYTES;
  localparam int unsigned NBURSTS        = BEATS_PER_PAGE / BURST_BEATS;
  localparam int unsigned BURST_SHIFT    = $clog2(BURST_BEATS * BYTES);
  localparam int unsigned BEAT_W         = $clog2(BEATS_PER_PAGE + 1);
  localparam int unsigned BURST_W        = $clog2(NBURSTS + 1);
  localparam int unsigned OUTS_W         = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS_PER_PAGE - 1);
  localparam logic [BEAT_W-1:0]     BURST_MASK = BEAT_W'(BURST_BEATS - 1);
  localparam logic [BURST_W-1:0]    NBURSTS_C  = BURST_W'(NBURSTS);
  localparam logic [OUTS_W-1:0]     MAX_OUTS_C = OUTS_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] PAGE_MASK  = ~(ADDR_WIDTH'(PAGE_BYTES - 1));
  localparam logic [ID_WIDTH-1:0]   RD_ID_C    = ID_WIDTH'(RD_ID);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [BURST_W-1:0]    issued_q, issued_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [OUTS_W-1:0]     outs_q, outs_d;
  logic                  err_q, err_d;

  logic                  busy_c;
  logic                  ar_valid_c;
  logic [ADDR_WIDTH-1:0] ar_addr_c;
  logic                  ar_fire_c;
  logic                  r_fire_c;
  logic                  rlast_exp_c;
  logic                  r_bad_c;

  // AR and R channel decode; AR fields are zero whenever arvalid is low (including reset)
  always_comb begin
    busy_c      = (state_q == S_BUSY);
    ar_valid_c  = busy_c && (issued_q < NBURSTS_C) && (outs_q < MAX_OUTS_C);
    ar_addr_c   = base_q + (ADDR_WIDTH'(issued_q) << BURST_SHIFT);
    ar_fire_c   = ar_valid_c && m_axi_arready;
    r_fire_c    = busy_c && m_axi_rvalid && out_ready;
    rlast_exp_c = ((beat_q & BURST_MASK) == BURST_MASK);
    r_bad_c     = (m_axi_rresp != 2'b00) || (m_axi_rid != RD_ID_C) || (m_axi_rlast != rlast_exp_c);
  end

  assign req_ready     = (state_q == S_IDLE) && rst_n;
  assign m_axi_arvalid = ar_valid_c;
  assign m_axi_araddr  = ar_valid_c ? ar_addr_c : '0;
  assign m_axi_arlen   = ar_valid_c ? 8'(BURST_BEATS - 1) : 8'd0;
  assign m_axi_arsize  = ar_valid_c ? 3'($clog2(BYTES)) : 3'd0;
  assign m_axi_arburst = ar_valid_c ? 2'b01 : 2'b00;
  assign m_axi_arid    = ar_valid_c ? RD_ID_C : '0;
  assign m_axi_rready  = busy_c && out_ready;
  assign out_valid     = busy_c && m_axi_rvalid;
  assign out_data      = m_axi_rdata;
  assign out_last      = busy_c && (beat_q == LAST_BEAT);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;

  // Next-state and counter updates
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    issued_d = issued_q;
    beat_d   = beat_q;
    outs_d   = outs_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d  = S_BUSY;
          base_d   = req_addr & PAGE_MASK;
          issued_d = '0;
          beat_d   = '0;
          outs_d   = '0;
          err_d    = 1'b0;
        end
      end
      S_BUSY: begin
        if (ar_fire_c) begin
          issued_d = issued_q + BURST_W'(1);
        end
        // A stray early rlast must not wrap the in-flight count
        unique case ({ar_fire_c, r_fire_c && m_axi_rlast})
          2'b10:   outs_d = outs_q + OUTS_W'(1);
          2'b01:   outs_d = (outs_q != '0) ? outs_q - OUTS_W'(1) : outs_q;
          default: outs_d = outs_q;
        endcase
        if (r_fire_c) begin
          beat_d = beat_q + BEAT_W'(1);
          if (r_bad_c) begin
            err_d = 1'b1;
          end
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      issued_q <= '0;
      beat_q   <= '0;
      outs_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      issued_q <= issued_d;
      beat_q   <= beat_d;
      outs_q   <= outs_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_hawk_page_rd_seq.sv
// Scoreboard bench for hawk_page_rd_seq: directed pages against a modelled AXI read responder.
module tb_hawk_page_rd_seq;

  localparam int unsigned DW = 512;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [IW-1:0] m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          done;
  logic          err;

  int checks = 0;
  int failures = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  bit page_active = 1'b0;

  bit ar_rand = 1'b0;
  bit rv_rand = 1'b0;
  bit or_rand = 1'b0;
  bit hold_mode = 1'b0;
  int err_beat = -1;
  int rlast_beat = -1;

  logic [AW-1:0] exp_ar[$];
  beat_t         exp_out[$];
  bit            exp_err[$];

  always #5 clk = ~clk;

  hawk_page_rd_seq #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .RD_ID(3),
    .PAGE_BYTES(4096), .BURST_BEATS(8), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .done(done), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // AXI read responder: accepts ARs, returns 8 beats per burst with address-derived data
  initial begin : responder
    logic [AW-1:0] pend[$];
    logic [AW-1:0] aaddr;
    int  bib;
    int  gbeat;
    int  outst;
    bit  ar_hs;
    bit  r_hs;
    bib = 0; gbeat = 0; outst = 0;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
    m_axi_rid = 4'd3; m_axi_rdata = '0; m_axi_arready = 1'b1; out_ready = 1'b1;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      aaddr = m_axi_araddr;
      r_hs  = m_axi_rvalid && m_axi_rready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend.delete();
        bib = 0; gbeat = 0; outst = 0;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
        continue;
      end
      if (ar_hs) begin
        pend.push_back(aaddr);
        outst++;
      end
      if (r_hs) begin
        bib   = (bib + 1) % 8;
        gbeat = (gbeat + 1) % 64;
        if (bib == 0) begin
          void'(pend.pop_front());
          outst--;
        end
        m_axi_rvalid = 1'b0;
      end
      if (hold_mode) begin
        checks++;
        if (outst > 2) begin
          failures++;
          $display("FAIL outstanding_limit: got %0d bursts in flight, expected at most 2", outst);
        end
      end
      if (!m_axi_rvalid && pend.size() > 0 && (!rv_rand || $urandom_range(0, 3) == 0))
        m_axi_rvalid = 1'b1;
      if (m_axi_rvalid) begin
        m_axi_rdata = {16{pend[0] + 32'(bib * 64)}};
        m_axi_rlast = (bib == 7) || (gbeat == rlast_beat);
        m_axi_rresp = (gbeat == err_beat) ? 2'b10 : 2'b00;
        m_axi_rid   = 4'd3;
      end else begin
        m_axi_rlast = 1'b0;
        m_axi_rresp = 2'b00;
      end
      m_axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready     = or_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // AR monitor: field checks on each handshake and stability while stalled
  initial begin : ar_mon
    bit            stall;
    logic [AW-1:0] stall_addr;
    logic [AW-1:0] e;
    stall = 1'b0;
    stall_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        checks++;
        if (!m_axi_arvalid || m_axi_araddr !== stall_addr) begin
          failures++;
          $display("FAIL ar_stable: got valid=%b addr=%h expected valid=1 addr=%h",
                   m_axi_arvalid, m_axi_araddr, stall_addr);
        end
      end
      if (m_axi_arvalid && m_axi_arready) begin
        checks++;
        if (exp_ar.size() == 0) begin
          failures++;
          $display("FAIL ar_unexpected: got addr=%h expected no AR", m_axi_araddr);
        end else begin
          e = exp_ar.pop_front();
          if (m_axi_araddr !== e || m_axi_arlen !== 8'd7 || m_axi_arsize !== 3'd6 ||
              m_axi_arburst !== 2'b01 || m_axi_arid !== 4'd3) begin
            failures++;
            $display("FAIL ar_fields: got addr=%h len=%0d size=%0d burst=%0d id=%0d expected addr=%h len=7 size=6 burst=1 id=3",
                     m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid, e);
          end
        end
      end
      stall = m_axi_arvalid && !m_axi_arready;
      stall_addr = m_axi_araddr;
    end
  end

  // Output stream monitor
  initial begin : out_mon
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (m_axi_rvalid && page_active) begin
        checks++;
        if (out_valid !== 1'b1 || m_axi_rready !== out_ready) begin
          failures++;
          $display("FAIL rready_mirror: got out_valid=%b rready=%b expected out_valid=1 rready=%b",
                   out_valid, m_axi_rready, out_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_out.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected: got data=%h expected no beat", out_data);
        end else begin
          b = exp_out.pop_front();
          if (out_data !== b.data || out_last !== b.last) begin
            failures++;
            $display("FAIL out_beat %0d: got data=%h last=%b expected data=%h last=%b",
                     out_cnt, out_data, out_last, b.data, b.last);
          end
        end
        out_cnt++;
      end
    end
  end

  // Completion monitor
  initial begin : done_mon
    bit e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        checks++;
        if (exp_err.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected: got done=1 expected no completion");
        end else begin
          e = exp_err.pop_front();
          if (err !== e) begin
            failures++;
            $display("FAIL done_err: got err=%b expected %b", err, e);
          end
        end
        chk("done_quiet", 64'({out_valid, m_axi_rready, m_axi_arvalid, req_ready}), 64'd0);
        done_cnt++;
        page_active = 1'b0;
      end
    end
  end

  task automatic start_page(input logic [AW-1:0] addr, input bit e);
    logic [AW-1:0] base;
    beat_t b;
    bit got;
    base = addr & 32'hFFFF_F000;
    for (int i = 0; i < 8; i++) exp_ar.push_back(base + 32'(i) * 32'h200);
    for (int i = 0; i < 64; i++) begin
      b.data = {16{base + 32'(i * 64)}};
      b.last = (i == 63);
      exp_out.push_back(b);
    end
    exp_err.push_back(e);
    out_cnt = 0;
    @(posedge clk);
    #2;
    req_valid = 1'b1;
    req_addr = addr;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = req_ready;
      @(posedge clk);
      #2;
    end
    req_valid = 1'b0;
    page_active = 1'b1;
    chk("req_handshake", 64'(got), 64'd1);
    @(negedge clk);
    chk("busy_req_ready", 64'(req_ready), 64'd0);
  endtask

  task automatic wait_done();
    int start;
    bit ok;
    start = done_cnt;
    ok = 1'b0;
    for (int n = 0; n < 4000 && !ok; n++) begin
      @(posedge clk);
      if (done_cnt != start) ok = 1'b1;
    end
    chk("done_timeout", 64'(ok), 64'd1);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got no end of run expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit ok;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_ar", 64'({m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid}), 64'd0);
    chk("rst_out", 64'({out_valid, m_axi_rready, out_last, done, err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Basic page, unaligned request address
    start_page(32'h8000_1234, 1'b0);
    wait_done();

    // Slow responder and random arready: in-flight limit and AR stability
    ar_rand = 1'b1; rv_rand = 1'b1; hold_mode = 1'b1;
    start_page(32'h0000_5000, 1'b0);
    wait_done();
    ar_rand = 1'b0; rv_rand = 1'b0; hold_mode = 1'b0;

    // Error response on beat 17
    err_beat = 17;
    start_page(32'h2000_0000, 1'b1);
    wait_done();
    err_beat = -1;

    // Random out_ready backpressure; err must be cleared by the new command
    or_rand = 1'b1;
    start_page(32'h1234_7FFF, 1'b0);
    wait_done();
    or_rand = 1'b0;

    // Early rlast on beat 5
    rlast_beat = 5;
    start_page(32'h3000_0ABC, 1'b1);
    wait_done();
    rlast_beat = -1;

    // Reset mid-page at beat 30, then a clean page
    start_page(32'h5555_5000, 1'b0);
    ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(posedge clk);
      if (out_cnt >= 30) ok = 1'b1;
    end
    chk("reach_beat30", 64'(ok), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 64'({m_axi_arvalid, m_axi_rready, out_valid, out_last, done, req_ready, err}), 64'd0);
    chk("midrst_araddr", 64'(m_axi_araddr), 64'd0);
    exp_ar.delete();
    exp_out.delete();
    exp_err.delete();
    page_active = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    start_page(32'h4000_3000, 1'b0);
    wait_done();

    repeat (5) @(posedge clk);
    chk("ar_queue_empty", 64'(exp_ar.size()), 64'd0);
    chk("out_queue_empty", 64'(exp_out.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_err.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
